// File: rtl/seq_stream_pkg.sv
// Shared constants for the serial-pattern stream controller: FSM encoding,
// drain/length sizing helpers and the detector pattern constants.
package seq_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned MAX_HIT_LAT = 4;
  localparam int unsigned DRAIN_W     = $clog2(MAX_HIT_LAT + 1);

  // Width of the job length field for a given word width (holds 0..w).
  function automatic int unsigned len_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned PAT_W     = 6;
  localparam logic [5:0]  PAT_MODE1 = 6'b110010;
  localparam logic [5:0]  PAT_MODE0 = 6'b110110;

endpackage

// File: rtl/seq_stream_shifter.sv
// Parallel-load, MSB-first shift register with a remaining-bit counter.
// 'last' flags the cycle on which the final bit is presented.
module seq_stream_shifter #(
  parameter int WORD_W = 16,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              shift,
  output logic              msb,
  output logic              last
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = load_word;
      cnt_d = load_len;
    end else if (shift) begin
      sr_d = {sr_q[WORD_W-2:0], 1'b0};
      if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb  = sr_q[WORD_W-1];
  assign last = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/seq_stream_ctrl.sv
// Job controller feeding a serial pattern detector and counting its hits.
// Define SEQ_STREAM_CTRL_POS_EN to add first_pos/first_vld hit position outputs.
module seq_stream_ctrl
  import seq_stream_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int CNT_W   = 8,
  parameter int HIT_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_word,
  input  logic [$clog2(WORD_W+1)-1:0] in_len,
  input  logic                        in_mode,
  input  logic                        abort,
  output logic                        det_x,
  output logic                        det_mode,
  output logic                        det_en,
  output logic                        det_clr,
  input  logic                        det_hit,
  output logic                        busy,
  output logic                        done,
`ifdef SEQ_STREAM_CTRL_POS_EN
  output logic [$clog2(WORD_W)-1:0]   first_pos,
  output logic                        first_vld,
`endif
  output logic [CNT_W-1:0]            hit_count
);

  localparam int LEN_W = len_w(WORD_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WORD_W);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [LEN_W-1:0]   eff_len;
  logic               load, shift, sh_msb, sh_last, sample, clr_job;

  assign eff_len = (in_len == '0 || in_len > LEN_MAX) ? LEN_MAX : in_len;

  seq_stream_shifter #(.WORD_W(WORD_W), .LEN_W(LEN_W)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_word(in_word),
    .load_len (eff_len),
    .shift    (shift),
    .msb      (sh_msb),
    .last     (sh_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // abort wins over every forward transition once a job is under way
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_CLEAR;
      ST_CLEAR: state_d = abort ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (abort) state_d = ST_IDLE;
                else if (sh_last) state_d = ST_DRAIN;
      ST_DRAIN: if (abort) state_d = ST_IDLE;
                else if (drain_q == DRAIN_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE);
    det_clr  = (state_q == ST_CLEAR);
    det_en   = (state_q == ST_SHIFT) && !abort;
    det_x    = (state_q == ST_SHIFT) ? sh_msb : 1'b0;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    det_mode = mode_q;
  end

  // Datapath controls: an aborted cycle neither advances the shifter nor counts.
  always_comb begin
    load    = (state_q == ST_IDLE) && in_valid;
    shift   = (state_q == ST_SHIFT) && !abort;
    clr_job = (state_q == ST_CLEAR) && !abort;
    sample  = (state_q == ST_SHIFT || state_q == ST_DRAIN) && !abort && det_hit;
    mode_d  = load ? in_mode : mode_q;
    drain_d = drain_q;
    if (state_q == ST_SHIFT && sh_last) drain_d = DRAIN_W'(HIT_LAT);
    else if (state_q == ST_DRAIN && drain_q != '0) drain_d = drain_q - DRAIN_W'(1);
    hit_count_d = hit_count_q;
    if (clr_job) hit_count_d = '0;
    else if (sample && hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      drain_q     <= '0;
      hit_count_q <= '0;
    end else begin
      mode_q      <= mode_d;
      drain_q     <= drain_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign hit_count = hit_count_q;

`ifdef SEQ_STREAM_CTRL_POS_EN
  localparam int POS_W = $clog2(WORD_W);
  localparam int IDX_W = $clog2(WORD_W + MAX_HIT_LAT + 1) + 1;

  logic [IDX_W-1:0] idx_q, idx_d, rel;
  logic [POS_W-1:0] first_pos_q, first_pos_d;
  logic             first_vld_q, first_vld_d;

  // idx counts SHIFT/DRAIN cycles; a hit reports the bit HIT_LAT cycles back
  always_comb begin
    rel         = idx_q - IDX_W'(HIT_LAT);
    idx_d       = idx_q;
    first_pos_d = first_pos_q;
    first_vld_d = first_vld_q;
    if (clr_job) begin
      idx_d       = '0;
      first_pos_d = '0;
      first_vld_d = 1'b0;
    end else begin
      if (state_q == ST_SHIFT || state_q == ST_DRAIN) idx_d = idx_q + IDX_W'(1);
      if (sample && !first_vld_q) begin
        first_pos_d = rel[POS_W-1:0];
        first_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      first_pos_q <= '0;
      first_vld_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      first_pos_q <= first_pos_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign first_pos = first_pos_q;
  assign first_vld = first_vld_q;
`endif

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench for seq_stream_ctrl: behavioural detector, directed vector table,
// abort/reset sequences and randomized jobs against a pattern-scan model.
module tb_seq_stream_ctrl;
  import seq_stream_pkg::*;

  localparam int WW = 16;
  localparam int HL = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_mode = 1'b0, abort = 1'b0;
  logic [15:0] in_word = '0;
  logic [4:0]  in_len = '0;
  logic        in_ready, det_x, det_mode, det_en, det_clr, det_hit, busy, done;
  logic [7:0]  hit_count;
  logic        s_ready, s_x, s_mode, s_en, s_clr, s_busy, s_done;
  logic [1:0]  s_count;
  logic        sat_hit = 1'b1;
`ifdef SEQ_STREAM_CTRL_POS_EN
  logic [3:0]  first_pos, s_pos;
  logic        first_vld, s_vld;
`endif

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  seq_stream_ctrl #(.WORD_W(WW), .CNT_W(8), .HIT_LAT(HL)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_len(in_len), .in_mode(in_mode), .abort(abort),
    .det_x(det_x), .det_mode(det_mode), .det_en(det_en), .det_clr(det_clr),
    .det_hit(det_hit), .busy(busy), .done(done),
`ifdef SEQ_STREAM_CTRL_POS_EN
    .first_pos(first_pos), .first_vld(first_vld),
`endif
    .hit_count(hit_count));

  // saturation instance: detector output stuck high, 2-bit counter
  seq_stream_ctrl #(.WORD_W(WW), .CNT_W(2), .HIT_LAT(HL)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ready),
    .in_word(in_word), .in_len(in_len), .in_mode(in_mode), .abort(abort),
    .det_x(s_x), .det_mode(s_mode), .det_en(s_en), .det_clr(s_clr),
    .det_hit(sat_hit), .busy(s_busy), .done(s_done),
`ifdef SEQ_STREAM_CTRL_POS_EN
    .first_pos(s_pos), .first_vld(s_vld),
`endif
    .hit_count(s_count));

  // Behavioural detector: bit history since clear, hit HL cycles after final bit.
  logic [5:0]    hist = '0;
  int            nbits = 0;
  logic [HL-1:0] hpipe = '0;
  logic          mnow;
  assign mnow    = det_en && nbits >= 5 &&
                   ({hist[4:0], det_x} == (det_mode ? PAT_MODE1 : PAT_MODE0));
  assign det_hit = hpipe[HL-1];
  always @(posedge clk) begin
    if (det_clr) begin
      hist <= '0; nbits <= 0; hpipe <= '0;
    end else begin
      hpipe <= {hpipe[HL-2:0], mnow};
      if (det_en) begin
        hist  <= {hist[4:0], det_x};
        nbits <= nbits + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan the sent bits for every (overlapping) 6-bit pattern window.
  task automatic ref_job(input logic [15:0] w, input int len, input logic mode,
                         output int eff, output int hits, output int pos);
    logic [5:0] pat;
    pat  = mode ? PAT_MODE1 : PAT_MODE0;
    eff  = (len == 0 || len > WW) ? WW : len;
    hits = 0;
    pos  = -1;
    for (int k = 5; k < eff; k++)
      if (w[20-k -: 6] == pat) begin
        hits++;
        if (pos < 0) pos = k;
      end
  endtask

  // Runs one job; lat counts cycles from the accept edge to the done cycle.
  task automatic run_job(input logic [15:0] w, input int len, input logic mode,
                         output int hits, output int lat, output int en_cnt,
                         output int xs, output int scnt, output int fvld, output int fpos);
    int c;
    @(negedge clk);
    in_word = w; in_len = len[4:0]; in_mode = mode; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1; en_cnt = 0; xs = 0; hits = -1; scnt = -1; fvld = -1; fpos = -1;
    c = 1;
    while (c < 64) begin
      if (det_en) begin
        en_cnt++;
        xs = (xs << 1) | int'(det_x);
      end
      if (done) begin
        lat = c; hits = hit_count; scnt = s_count;
`ifdef SEQ_STREAM_CTRL_POS_EN
        fvld = first_vld; fpos = first_pos;
`endif
        break;
      end
      @(negedge clk);
      c++;
    end
  endtask

  typedef struct {
    logic [15:0] word;
    int          len;
    logic        mode;
    int          exp_hits;
    int          exp_lat;
    int          exp_en;
    int          exp_pos;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int h, l, e, x, s, fv, fp, eff, rh, rp, nd;
    logic [15:0] w;
    logic m;
    int len;

    tbl[0] = '{16'hC800, 6, 1'b1, 1, 10, 6, 5};
    tbl[1] = '{16'hDB00, 9, 1'b0, 2, 13, 9, 5};
    tbl[2] = '{16'hC800, 6, 1'b0, 0, 10, 6, -1};
    tbl[3] = '{16'hFFFF, 0, 1'b1, 0, 20, 16, -1};
    tbl[4] = '{16'hC800, 20, 1'b1, 1, 20, 16, 5};

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_det_en", det_en, 0);
    chk("rst_det_clr", det_clr, 0);
    chk("rst_done", done, 0);
    chk("rst_hit_count", hit_count, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_job(tbl[i].word, tbl[i].len, tbl[i].mode, h, l, e, x, s, fv, fp);
      chk($sformatf("v%0d_hits", i), h, tbl[i].exp_hits);
      chk($sformatf("v%0d_lat", i), l, tbl[i].exp_lat);
      chk($sformatf("v%0d_en_cycles", i), e, tbl[i].exp_en);
      chk($sformatf("v%0d_stream", i), x, int'(tbl[i].word >> (16 - tbl[i].exp_en)));
      chk($sformatf("v%0d_sat_count", i), s, 3);
`ifdef SEQ_STREAM_CTRL_POS_EN
      chk($sformatf("v%0d_first_vld", i), fv, tbl[i].exp_pos >= 0 ? 1 : 0);
      if (tbl[i].exp_pos >= 0) chk($sformatf("v%0d_first_pos", i), fp, tbl[i].exp_pos);
`endif
      @(negedge clk);
      chk($sformatf("v%0d_idle_after_done", i), in_ready, 1);
    end

    // abort on the 3rd SHIFT cycle with a competing request held high
    @(negedge clk);
    in_word = 16'hC800; in_len = 5'd6; in_mode = 1'b1; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_shift_en", det_en, 1);
    abort = 1'b1; in_valid = 1'b1; in_word = 16'hFFFF;
    #1 chk("abort_busy_not_ready", in_ready, 0);
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_ready", in_ready, 1);
    chk("abort_idle_det_en", det_en, 0);
    chk("abort_hit_count", hit_count, 0);
    abort = 1'b0; in_valid = 1'b0;
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort_no_done_or_job", nd, 0);

    // reset asserted mid-SHIFT
    @(negedge clk);
    in_word = 16'hFFFF; in_len = 5'd0; in_mode = 1'b1; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_det_en", det_en, 0);
    chk("midrst_det_x", det_x, 0);
    chk("midrst_det_mode", det_mode, 0);
    chk("midrst_hit_count", hit_count, 0);
    @(negedge clk); rst_n = 1'b1;
    run_job(16'hC800, 6, 1'b1, h, l, e, x, s, fv, fp);
    chk("postrst_hits", h, 1);
    chk("postrst_lat", l, 10);

    // randomized jobs, roughly half with the mode's pattern planted
    for (int r = 0; r < 40; r++) begin
      w   = 16'($urandom);
      m   = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 20);
      if ($urandom_range(0, 1) == 1) begin
        int p;
        p = $urandom_range(0, 10);
        w[15-p -: 6] = m ? PAT_MODE1 : PAT_MODE0;
      end
      ref_job(w, len, m, eff, rh, rp);
      run_job(w, len, m, h, l, e, x, s, fv, fp);
      chk($sformatf("r%0d_hits", r), h, rh);
      chk($sformatf("r%0d_lat", r), l, eff + HL + 2);
      chk($sformatf("r%0d_en_cycles", r), e, eff);
      chk($sformatf("r%0d_stream", r), x, int'(w >> (16 - eff)));
`ifdef SEQ_STREAM_CTRL_POS_EN
      chk($sformatf("r%0d_first_vld", r), fv, rp >= 0 ? 1 : 0);
      if (rp >= 0) chk($sformatf("r%0d_first_pos", r), fp, rp);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Controller that feeds a serial pattern detector (110010 / 110110 family) from a parallel word.
- Accepts a word, bit length and mode over a valid/ready handshake, clears the detector, then shifts the word MSB-first into the detector's x input with the mode held on the detector's mode line.
- Collects detector hits into a saturating count and reports completion.
- Sits between a register/host interface and the detector core.

Parameters:
- WORD_W, 16, width of the pattern word and maximum bits per job.
- CNT_W, 8, width of hit_count.
- HIT_LAT, 2, cycles from a bit's det_en cycle to its det_hit response; range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  job request.
- in_ready  out  1  controller can accept a job.
- in_word  in  WORD_W  bits to stream; bit WORD_W-1 is sent first.
- in_len  in  $clog2(WORD_W+1)  number of bits to send.
- in_mode  in  1  detector mode (btn equivalent), latched per job.
- abort  in  1  synchronous job cancel.
- det_x  out  1  serial bit to the detector.
- det_mode  out  1  mode to the detector.
- det_en  out  1  detector advance enable.
- det_clr  out  1  synchronous clear of the detector to its idle state.
- det_hit  in  1  detector match output.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- hit_count  out  CNT_W  hits in the current or last job.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE.
  - in_ready=1.
  - det_x, det_mode, det_en, det_clr, busy, done all 0.
  - hit_count=0; shift register and counters 0.
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE (one-hot or binary; encoding lives in the package).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_word, in_mode and the effective length, then go to CLEAR.
  - Effective length: in_len=0 or in_len>WORD_W clamps to WORD_W.
- CLEAR (1 cycle):
  - det_clr=1, det_en=0, hit_count<=0, det_mode<=latched mode.
  - Go to SHIFT.
- SHIFT:
  - det_en=1; det_x = shift register MSB; shift left by one each cycle.
  - Exactly len cycles, then go to DRAIN with drain counter = HIT_LAT.
- DRAIN:
  - det_en=0, det_x=0.
  - Decrement the drain counter each cycle; after HIT_LAT cycles go to DONE.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - hit_count holds until the next CLEAR.
- busy=1 in CLEAR, SHIFT, DRAIN and DONE.
- det_mode stays constant from CLEAR through DONE.
- Hit sampling:
  - Sample det_hit on every cycle in SHIFT and DRAIN.
  - Each sampled 1 increments hit_count; saturate at 2^CNT_W-1.
  - det_hit is ignored in IDLE, CLEAR and DONE.
- Latency: accept-to-done = 1 (CLEAR) + len + HIT_LAT + 1 cycles.
- abort:
  - In CLEAR, SHIFT or DRAIN: go to IDLE next cycle, det_en=0, no done pulse, hit_count frozen.
  - In IDLE or DONE: abort is ignored.
  - Simultaneous in_valid and abort in IDLE: the job is accepted.
- Reset mid-job: immediate return to the reset values; the detector is cleared by the next job's CLEAR.

Optional Feature:
- Macro: SEQ_STREAM_CTRL_POS_EN.
- Defined:
  - Adds output first_pos [$clog2(WORD_W)-1:0] and first_vld (1 bit).
  - On the first sampled hit of a job, first_pos = (SHIFT/DRAIN cycle index since the first SHIFT cycle) - HIT_LAT, i.e. the index of the last bit of the matched sequence; first_vld=1.
  - Both are cleared in CLEAR.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package seq_stream_pkg holds:
  - the state encoding constants,
  - the length-clamp width constant,
  - the two pattern constants (6'b110010 for mode 1, 6'b110110 for mode 0), which the bench model uses.
- One natural sub-module: seq_stream_shifter.
  - Parallel load, MSB-first shift and bit counter, with load/shift/last handshake to the FSM.
  - The FSM, hit counter and position logic stay in the top module.

Test Plan:
Bench instantiates a behavioural detector asserting det_hit HIT_LAT cycles after the final bit of the mode's pattern; WORD_W=16, CNT_W=8, HIT_LAT=2.
- Reset: assert rst_n=0 mid-SHIFT -> all outputs 0 and in_ready=1 immediately; the next job runs normally.
- Single hit: in_word=16'hC800, in_len=6, in_mode=1 -> det_x streams 110010; done 10 cycles after accept; hit_count=1; first_pos=5 with POS_EN.
- Mode 0, overlapping: in_word=16'b1101101100000000, in_len=9, in_mode=0 -> two hits (bits 0-5 and 3-8); hit_count=2.
- Wrong mode: in_word=16'hC800, in_len=6, in_mode=0 -> hit_count=0, done still pulses.
- Clamp and saturation: in_len=0 -> exactly 16 det_en cycles. Separately, force det_hit=1 with CNT_W=2 -> hit_count sticks at 3.
- Abort: abort asserted on the 3rd SHIFT cycle -> IDLE next cycle, det_en=0, no done pulse, in_ready=1; in_valid while busy is not accepted.
